// File: rtl/decode_stage_pp.sv
// Registered MIPS instruction-decode stage: IF/ID register, field split, class decode,
// immediate/target generation, load-use bubble insertion and the ID/EX register.
module decode_stage_pp #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ZERO_EXT_LOGIC = 1,
    parameter int HAZARD_EN      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [ADDR_W-1:0] if_pc4,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              if_stall,
    output logic              id_valid,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_funct,
    output logic [DATA_W-1:0] id_imm_ext,
    output logic [ADDR_W-1:0] id_branch_target,
    output logic [ADDR_W-1:0] id_jump_target,
    output logic [ADDR_W-1:0] id_pc4,
    output logic              id_is_rtype,
    output logic              id_is_load,
    output logic              id_is_store,
    output logic              id_is_branch,
    output logic              id_is_jump,
    output logic              id_is_link,
    output logic              id_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic              ifid_valid;
    logic [31:0]       ifid_instr;
    logic [ADDR_W-1:0] ifid_pc4;

    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [15:0]       imm16;
    logic              d_rtype, d_load, d_store, d_branch, d_jump, d_link, d_illegal;
    logic              uses_rs, uses_rt;
    logic [DATA_W-1:0] d_imm;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] d_branch_target;
    logic [ADDR_W-1:0] d_jump_target;
    logic              hazard;

    assign op    = ifid_instr[31:26];
    assign rs    = ifid_instr[25:21];
    assign rt    = ifid_instr[20:16];
    assign imm16 = ifid_instr[15:0];

    always_comb begin
        d_rtype   = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_link    = 1'b0;
        d_illegal = 1'b0;
        uses_rs   = 1'b1;
        uses_rt   = 1'b0;
        case (op)
            OP_RTYPE: begin
                d_rtype = 1'b1;
                uses_rt = 1'b1;
            end
            OP_LW: d_load = 1'b1;
            OP_SW: begin
                d_store = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d_branch = 1'b1;
                uses_rt  = 1'b1;
            end
            OP_J: begin
                d_jump  = 1'b1;
                uses_rs = 1'b0;
            end
            OP_JAL: begin
                d_jump  = 1'b1;
                d_link  = 1'b1;
                uses_rs = 1'b0;
            end
            OP_LUI: uses_rs = 1'b0;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: ;
            default: d_illegal = 1'b1;
        endcase
    end

    // lui places imm in the upper half before extension; logical ops may zero-extend.
    always_comb begin
        d_imm = DATA_W'($signed(imm16));
        if (op == OP_LUI)
            d_imm = DATA_W'($signed({imm16, 16'h0000}));
        else if ((ZERO_EXT_LOGIC != 0) && (op == OP_ANDI || op == OP_ORI || op == OP_XORI))
            d_imm = DATA_W'(imm16);
    end

    assign br_off          = ADDR_W'($signed(imm16)) << 2;
    assign d_branch_target = ifid_pc4 + br_off;

    generate
        if (ADDR_W > 28) begin : g_jt_region
            assign d_jump_target = {ifid_pc4[ADDR_W-1:28], ifid_instr[25:0], 2'b00};
        end else begin : g_jt_flat
            assign d_jump_target = {ifid_instr[25:0], 2'b00};
        end
    endgenerate

    // The bubble clears id_is_load, so a single load can never stall twice.
    assign hazard = (HAZARD_EN != 0) && ifid_valid && id_valid && id_is_load &&
                    (id_rt != 5'd0) &&
                    ((uses_rs && (rs == id_rt)) || (uses_rt && (rt == id_rt)));

    assign if_stall = !rst && !flush && (ex_stall || hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (!ex_stall && !hazard) begin
            ifid_valid <= if_valid;
            ifid_instr <= if_instr;
            ifid_pc4   <= if_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid         <= 1'b0;
            id_opcode        <= '0;
            id_rs            <= '0;
            id_rt            <= '0;
            id_rd            <= '0;
            id_shamt         <= '0;
            id_funct         <= '0;
            id_imm_ext       <= '0;
            id_branch_target <= '0;
            id_jump_target   <= '0;
            id_pc4           <= '0;
            id_is_rtype      <= 1'b0;
            id_is_load       <= 1'b0;
            id_is_store      <= 1'b0;
            id_is_branch     <= 1'b0;
            id_is_jump       <= 1'b0;
            id_is_link       <= 1'b0;
            id_illegal       <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (ex_stall) begin
            id_valid <= id_valid;
        end else if (hazard) begin
            id_valid     <= 1'b0;
            id_is_rtype  <= 1'b0;
            id_is_load   <= 1'b0;
            id_is_store  <= 1'b0;
            id_is_branch <= 1'b0;
            id_is_jump   <= 1'b0;
            id_is_link   <= 1'b0;
            id_illegal   <= 1'b0;
        end else begin
            id_valid         <= ifid_valid;
            id_opcode        <= op;
            id_rs            <= rs;
            id_rt            <= rt;
            id_rd            <= ifid_instr[15:11];
            id_shamt         <= ifid_instr[10:6];
            id_funct         <= ifid_instr[5:0];
            id_imm_ext       <= d_imm;
            id_branch_target <= d_branch_target;
            id_jump_target   <= d_jump_target;
            id_pc4           <= ifid_pc4;
            id_is_rtype      <= d_rtype;
            id_is_load       <= d_load;
            id_is_store      <= d_store;
            id_is_branch     <= d_branch;
            id_is_jump       <= d_jump;
            id_is_link       <= d_link;
            id_illegal       <= d_illegal;
        end
    end

endmodule
